// File: rtl/uart_block_tx_pkg.sv
// Shared constants for the AES-to-UART block serialiser and its FSM state encoding.
package uart_block_tx_pkg;

  localparam int         AES_BLOCK_BYTES   = 16;
  localparam int         UART_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam logic [7:0] SYNC_HEADER       = 8'hA5;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND      = 3'd1;
  localparam logic [2:0] ST_WAIT_DONE = 3'd2;
  localparam logic [2:0] ST_GAP       = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    SEND      = ST_SEND,
    WAIT_DONE = ST_WAIT_DONE,
    GAP       = ST_GAP,
    FINISH    = ST_FINISH
  } state_t;

endpackage

// File: rtl/uart_block_tx.sv
// Serialises one wide block MSB-byte-first into uart_tx, optionally prefixed by a sync header.
// First o_Tx_DV two cycles after i_Block_DV; each byte waits for i_Tx_Active low and i_Tx_Done.
module uart_block_tx
  import uart_block_tx_pkg::*;
#(
  parameter int         BLOCK_BYTES = AES_BLOCK_BYTES,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BYTE = SYNC_HEADER
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_Block_DV,
  input  logic [8*BLOCK_BYTES-1:0] i_Block,
  output logic                     o_Block_Ready,
  output logic                     o_Tx_DV,
  output logic [7:0]               o_Tx_Byte,
  input  logic                     i_Tx_Active,
  input  logic                     i_Tx_Done,
  output logic                     o_Busy,
  output logic                     o_Done
);

  localparam int            BW       = 8 * BLOCK_BYTES;
  localparam int            CW       = $clog2(BLOCK_BYTES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BLOCK_BYTES - 1 + HEADER_EN);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] shreg, shreg_n;
  logic          hdr_pend, hdr_pend_n;
  logic          tx_dv_n, busy_n, done_n, ready_n;
  logic [7:0]    tx_byte_n;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      shreg         <= '0;
      hdr_pend      <= 1'b0;
      o_Tx_DV       <= 1'b0;
      o_Tx_Byte     <= 8'h00;
      o_Busy        <= 1'b0;
      o_Done        <= 1'b0;
      o_Block_Ready <= 1'b1;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      shreg         <= shreg_n;
      hdr_pend      <= hdr_pend_n;
      o_Tx_DV       <= tx_dv_n;
      o_Tx_Byte     <= tx_byte_n;
      o_Busy        <= busy_n;
      o_Done        <= done_n;
      o_Block_Ready <= ready_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shreg_n    = shreg;
    hdr_pend_n = hdr_pend;
    tx_dv_n    = 1'b0;
    tx_byte_n  = o_Tx_Byte;
    busy_n     = o_Busy;
    done_n     = 1'b0;
    ready_n    = o_Block_Ready;

    unique case (state)
      IDLE: begin
        if (i_Block_DV) begin
          shreg_n    = i_Block;
          cnt_n      = CNT_LOAD;
          hdr_pend_n = (HEADER_EN != 0);
          busy_n     = 1'b1;
          ready_n    = 1'b0;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (!i_Tx_Active) begin
          tx_dv_n   = 1'b1;
          tx_byte_n = hdr_pend ? HEADER_BYTE : shreg[BW-1 -: 8];
          state_n   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_Tx_Done) begin
          // The header consumes a count slot but leaves the payload in place.
          if (hdr_pend) hdr_pend_n = 1'b0;
          else          shreg_n    = shreg << 8;
          if (cnt == '0) begin
            state_n = FINISH;
          end else begin
            cnt_n   = cnt - CW'(1);
            state_n = GAP;
          end
        end
      end
      GAP: state_n = SEND;
      FINISH: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        ready_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_block_tx.sv
// Bench for uart_block_tx: a uart_tx stand-in paces bytes and logs them against a scoreboard.
`timescale 1ns/1ps
module tb_uart_block_tx;

  localparam int BYTE_CYC = 40;  // 10 bits at 4 clocks per bit

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         blk_dv0, blk_dv1;
  logic [127:0] blk0;
  logic [7:0]   blk1;
  logic         ready0, ready1, busy0, busy1, odone0, odone1;
  logic         txdv   [2];
  logic [7:0]   txbyte [2];
  logic         active [2];
  logic         done   [2] = '{1'b0, 1'b0};
  logic         hold   [2];
  int           stub_cnt  [2] = '{0, 0};
  logic [7:0]   stub_byte [2];

  int cyc = 0, last_done0 = -1000000, min_gap0 = 1000000;
  int viol0 = 0, odone_cnt0 = 0;
  logic [7:0] rx_q0[$], rx_q1[$], exp_q0[$], exp_q1[$];
  int n_cmp, n_err;

  uart_block_tx u_dut (
    .i_Clock(clk), .i_Reset(rst), .i_Block_DV(blk_dv0), .i_Block(blk0),
    .o_Block_Ready(ready0), .o_Tx_DV(txdv[0]), .o_Tx_Byte(txbyte[0]),
    .i_Tx_Active(active[0]), .i_Tx_Done(done[0]), .o_Busy(busy0), .o_Done(odone0)
  );

  uart_block_tx #(.BLOCK_BYTES(1), .HEADER_EN(0)) u_dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Block_DV(blk_dv1), .i_Block(blk1),
    .o_Block_Ready(ready1), .o_Tx_DV(txdv[1]), .o_Tx_Byte(txbyte[1]),
    .i_Tx_Active(active[1]), .i_Tx_Done(done[1]), .o_Busy(busy1), .o_Done(odone1)
  );

  assign active[0] = (stub_cnt[0] != 0) || hold[0];
  assign active[1] = (stub_cnt[1] != 0) || hold[1];

  // uart_tx stand-in: busy for one byte time after a strobe, then a one-cycle done.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      done[i] <= 1'b0;
      if (stub_cnt[i] != 0) begin
        stub_cnt[i] <= stub_cnt[i] - 1;
        if (stub_cnt[i] == 1) done[i] <= 1'b1;
      end else if (txdv[i] && !hold[i]) begin
        stub_cnt[i]  <= BYTE_CYC;
        stub_byte[i] <= txbyte[i];
        if (i == 0) rx_q0.push_back(txbyte[i]);
        else        rx_q1.push_back(txbyte[i]);
      end
    end
    if (done[0]) last_done0 <= cyc;
    if (odone0) odone_cnt0 <= odone_cnt0 + 1;
    if (txdv[0] && (cyc - last_done0) < min_gap0) min_gap0 <= cyc - last_done0;
    if ((txdv[0] && (active[0] || !busy0)) ||
        (stub_cnt[0] != 0 && txbyte[0] !== stub_byte[0]))
      viol0 <= viol0 + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_block0(input logic [127:0] b, input int n);
    exp_q0.push_back(8'hA5);
    for (int k = 0; k < n - 1; k++) exp_q0.push_back(b[127 - 8*k -: 8]);
  endtask

  task automatic strobe0(input logic [127:0] b);
    @(negedge clk);
    blk0 = b; blk_dv0 = 1'b1;
    @(negedge clk);
    blk_dv0 = 1'b0;
  endtask

  task automatic wait_odone0(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = odone0;
    end
    chk({tag, "_done_seen"}, 128'(ok), 128'(1));
  endtask

  task automatic check_frames0(input string tag);
    chk({tag, "_byte_count"}, 128'(rx_q0.size()), 128'(exp_q0.size()));
    while (rx_q0.size() > 0 && exp_q0.size() > 0)
      chk({tag, "_byte"}, rx_q0.pop_front(), exp_q0.pop_front());
    rx_q0.delete();
    exp_q0.delete();
  endtask

  initial begin
    logic [127:0] b1, b3, b4, b5;
    bit seen, ok;
    int ndone;
    b1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    b3 = 128'h00112233445566778899aabbccddeeff;
    b4 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    b5 = 128'hdeadbeef0123456789abcdeffedcba98;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; blk_dv0 = 1'b0; blk_dv1 = 1'b0; blk0 = '0; blk1 = '0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready0, 1'b1);
    chk("rst_tx_dv", txdv[0], 1'b0);
    chk("rst_tx_byte", txbyte[0], 8'h00);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", odone0, 1'b0);
    chk("rst_ready1", ready1, 1'b1);
    rst = 1'b0;

    // Basic header + 16-byte frame, with first-byte latency.
    exp_block0(b1, 17);
    @(negedge clk);
    blk0 = b1; blk_dv0 = 1'b1;
    @(negedge clk);
    blk_dv0 = 1'b0;
    chk("lat_n1_dv", txdv[0], 1'b0);
    chk("accept_busy", busy0, 1'b1);
    chk("accept_ready", ready0, 1'b0);
    @(negedge clk);
    chk("lat_n2_dv", txdv[0], 1'b1);
    chk("first_byte_hdr", txbyte[0], 8'hA5);
    wait_odone0("basic");
    chk("basic_busy_clear", busy0, 1'b0);
    chk("basic_ready_set", ready0, 1'b1);
    @(negedge clk);
    chk("basic_done_one_cycle", odone0, 1'b0);
    chk("basic_done_count", 128'(odone_cnt0), 128'(1));
    check_frames0("basic");

    // Single-byte block without header.
    exp_q1.push_back(8'h3C);
    @(negedge clk);
    blk1 = 8'h3C; blk_dv1 = 1'b1;
    @(negedge clk);
    blk_dv1 = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      ok = odone1;
    end
    chk("one_byte_done_seen", 128'(ok), 128'(1));
    chk("one_byte_count", 128'(rx_q1.size()), 128'(exp_q1.size()));
    if (rx_q1.size() > 0 && exp_q1.size() > 0)
      chk("one_byte_value", rx_q1.pop_front(), exp_q1.pop_front());

    // Back-pressure from uart_tx, then a strobe while busy that must be dropped.
    hold[0] = 1'b1;
    exp_block0('0, 17);
    strobe0('0);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (txdv[0]) seen = 1'b1;
    end
    chk("bp_no_dv_while_active", 128'(seen), 128'(0));
    hold[0] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      ok = txdv[0];
    end
    chk("bp_dv_after_release", 128'(ok), 128'(1));
    chk("bp_byte_hdr", txbyte[0], 8'hA5);
    for (int k = 0; k < 1000 && rx_q0.size() < 3; k++) @(negedge clk);
    chk("busy_strobe_ready_low", ready0, 1'b0);
    strobe0({128{1'b1}});
    wait_odone0("busy_strobe");
    check_frames0("busy_strobe");
    repeat (200) @(negedge clk);
    chk("busy_strobe_no_second", 128'(rx_q0.size()), 128'(0));
    chk("busy_strobe_idle", busy0, 1'b0);

    // Reset asserted in the cycle of the 5th byte completion.
    exp_block0(b3, 5);
    strobe0(b3);
    ndone = 0;
    for (int k = 0; k < 3000 && ndone < 5; k++) begin
      @(negedge clk);
      if (done[0]) ndone++;
    end
    chk("reset_fifth_done_seen", 128'(ndone), 128'(5));
    rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy0, 1'b0);
    chk("reset_ready", ready0, 1'b1);
    chk("reset_tx_dv", txdv[0], 1'b0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check_frames0("reset_mid");

    // Back-to-back blocks, the second offered the cycle ready rises.
    exp_block0(b4, 17);
    exp_block0(b5, 17);
    strobe0(b4);
    wait_odone0("b2b_first");
    chk("b2b_ready_rise", ready0, 1'b1);
    blk0 = b5; blk_dv0 = 1'b1;
    @(negedge clk);
    blk_dv0 = 1'b0;
    chk("b2b_second_accepted", busy0, 1'b1);
    wait_odone0("b2b_second");
    check_frames0("b2b");
    chk("min_done_to_dv_gap", 128'(min_gap0 >= 2), 128'(1));
    chk("protocol_violations", 128'(viol0), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
